// File: rtl/count_ones_imp.sv
// Sequential ones-counter: captures a word on a data_ready rising edge and shifts it out one
// bit per clock, accumulating the 1-bits. Define COUNT_ONES_EARLY_EXIT_EN to stop once sreg==0.
module count_ones_imp #(
  parameter int unsigned data_width  = 4,
  parameter int unsigned count_width = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [data_width-1:0]  data,
  input  logic                   data_ready,
  output logic [count_width-1:0] bit_count,
  output logic                   start,
  output logic                   done
);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e                 state_q, state_d;
  logic [data_width-1:0]  sreg_q, sreg_d;
  logic [count_width-1:0] bit_count_q, bit_count_d;
  logic                   start_q, start_d;
  logic                   done_q, done_d;
  logic                   dr_q;
  logic                   acc;
  logic                   term;

`ifdef COUNT_ONES_EARLY_EXIT_EN
  assign term = (sreg_q == '0);
`else
  localparam int unsigned ShiftWidth = $clog2(data_width + 1);
  logic [ShiftWidth-1:0] shift_q, shift_d;

  // Fixed latency: always shift every bit, regardless of content.
  assign term = (shift_q == ShiftWidth'(data_width));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shift_q <= '0;
    else       shift_q <= shift_d;
  end

  always_comb begin
    shift_d = shift_q;
    if ((state_q != StCount) && acc)      shift_d = '0;
    else if ((state_q == StCount) && !term) shift_d = shift_q + 1'b1;
  end
`endif

  assign acc = data_ready & ~dr_q;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_count_d = bit_count_q;
    start_d     = start_q;
    done_d      = done_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (acc) begin
          sreg_d      = data;
          bit_count_d = '0;
          start_d     = 1'b1;
          done_d      = 1'b0;
          state_d     = StCount;
        end
      end
      StCount: begin
        start_d = 1'b0;
        if (term) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          bit_count_d = bit_count_q + count_width'(sreg_q[0]);
          sreg_d      = sreg_q >> 1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      bit_count_q <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      dr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_count_q <= bit_count_d;
      start_q     <= start_d;
      done_q      <= done_d;
      dr_q        <= data_ready;
    end
  end

  assign bit_count = bit_count_q;
  assign start     = start_q;
  assign done      = done_q;

endmodule

// File: tb/tb_count_ones_imp.sv
// Randomized self-checking bench for count_ones_imp against a popcount/latency reference model.
module tb_count_ones_imp;

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data;
  logic          data_ready;
  logic [CW-1:0] bit_count;
  logic          start;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  count_ones_imp #(.data_width(DW), .count_width(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .data_ready(data_ready),
    .bit_count (bit_count),
    .start     (start),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_count(input logic [DW-1:0] w);
    int c = 0;
    for (int i = 0; i < int'(DW); i++) c += int'(w[i]);
    return c % (1 << CW);
  endfunction

  // Number of edges after E0 until done rises.
  function automatic int model_latency(input logic [DW-1:0] w);
`ifdef COUNT_ONES_EARLY_EXIT_EN
    int p = -1;
    for (int i = 0; i < int'(DW); i++) if (w[i]) p = i;
    return (p < 0) ? 1 : p + 2;
`else
    return int'(DW) + 1;
`endif
  endfunction

  // Called at the negedge just after E0. Optional pulse on data_ready during the count.
  task automatic finish_word(input logic [DW-1:0] w, input bit hold, input bit pulse);
    int lat = model_latency(w);
    check_val("start_after_e0", {31'd0, start}, 32'd1);
    check_val("done_after_e0", {31'd0, done}, 32'd0);
    check_val("count_after_e0", {29'd0, bit_count}, 32'd0);
    if (!hold) data_ready = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (pulse && k == 1) data_ready = 1'b1;
      if (pulse && k == 2) data_ready = 1'b0;
      check_val("start_pulse_only", {31'd0, start}, 32'd0);
      check_val("done_timing", {31'd0, done}, (k == lat) ? 32'd1 : 32'd0);
    end
    check_val("final_count", {29'd0, bit_count}, model_count(w));
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        check_val("hold_done", {31'd0, done}, 32'd1);
        check_val("hold_no_start", {31'd0, start}, 32'd0);
        check_val("hold_count", {29'd0, bit_count}, model_count(w));
      end
      data_ready = 1'b0;
    end
  endtask

  task automatic run_word(input logic [DW-1:0] w, input bit hold, input bit pulse);
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
    data       = w;
    data_ready = 1'b1;
    @(negedge clk);
    finish_word(w, hold, pulse);
  endtask

  initial begin
    reset      = 1'b1;
    data       = '0;
    data_ready = 1'b0;
    #1;
    check_val("reset_count", {29'd0, bit_count}, 32'd0);
    check_val("reset_start", {31'd0, start}, 32'd0);
    check_val("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_word(4'hf, 1'b0, 1'b0);
    run_word(4'h5, 1'b0, 1'b0);
    run_word(4'h0, 1'b0, 1'b0);
    run_word(4'ha, 1'b1, 1'b0);
    run_word(4'h9, 1'b0, 1'b1);
    run_word(4'h1, 1'b0, 1'b0);

    // Abort mid-count, then accept on the first edge after release.
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
    data       = 4'hb;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
    #2;
    reset      = 1'b1;
    data       = 4'h5;
    data_ready = 1'b1;
    #1;
    check_val("abort_count", {29'd0, bit_count}, 32'd0);
    check_val("abort_start", {31'd0, start}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    finish_word(4'h5, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) run_word(DW'($urandom), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
